// File: rtl/alarme_if.sv
// Time, control and display signals between the chrono counters/switches and the alarm unit.
interface alarme_if;
  logic [4:0] horas;
  logic [5:0] minutos;
  logic [5:0] segundos;
  logic       enable;
  logic       set_alarm;
  logic [4:0] ajuste_h;
  logic [5:0] ajuste_m;
  logic       snooze;
  logic       stop;
  logic [4:0] alarm_h;
  logic [5:0] alarm_m;
  logic       ringing;
  logic       led;
  logic       snooze_active;

  modport master (
    output horas, minutos, segundos, enable, set_alarm, ajuste_h, ajuste_m, snooze, stop,
    input  alarm_h, alarm_m, ringing, led, snooze_active
  );

  modport slave (
    input  horas, minutos, segundos, enable, set_alarm, ajuste_h, ajuste_m, snooze, stop,
    output alarm_h, alarm_m, ringing, led, snooze_active
  );
endinterface

// File: rtl/alarme.sv
// Alarm unit: synchronises the ripple-clocked time bus, matches alarm/snooze times and
// runs the IDLE/RINGING/SNOOZE machine with a blinking LED; 3-cycle input-to-state latency.
module alarme #(
  parameter int BLINK_DIV  = 25_000_000,
  parameter int SNOOZE_MIN = 5,
  parameter int RING_SEC   = 60
) (
  input logic     clock_50,
  input logic     reset,
  alarme_if.slave io
);
  typedef struct packed {
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
  } hms_t;

  typedef enum logic [1:0] {IDLE, RINGING, SNOOZE} state_t;

  hms_t        s1, s2, s3;
  logic [5:0]  last_seg;
  logic        sec_tick;
  logic [1:0]  snz_sync, stp_sync;
  logic        snz_prev, stp_prev, snz_edge, stp_edge;
  logic [4:0]  alarm_h, snz_h, snz_h_nx;
  logic [5:0]  alarm_m, snz_m, snz_m_nx;
  logic [6:0]  m_sum;
  logic        m_wrap;
  logic        alarm_hit, snz_hit, ring_done, enter_ring;
  logic [15:0] ring_cnt;
  logic [31:0] blink_cnt;
  logic        led;
  state_t      state, state_nx;

  // A tick needs two matching stages, so bus glitches shorter than 2 cycles are ignored
  assign sec_tick  = (s2 == s3) && (s3.s != last_seg);
  assign alarm_hit = sec_tick && (s3.h == alarm_h) && (s3.m == alarm_m) && (s3.s == 6'd0);
  assign snz_hit   = sec_tick && (s3.h == snz_h) && (s3.m == snz_m) && (s3.s == 6'd0);
  assign ring_done = sec_tick && ((ring_cnt + 16'd1) == 16'(RING_SEC));

  assign m_sum    = {1'b0, s3.m} + 7'(SNOOZE_MIN);
  assign m_wrap   = (m_sum >= 7'd60);
  assign snz_m_nx = m_wrap ? 6'(m_sum - 7'd60) : m_sum[5:0];
  assign snz_h_nx = m_wrap ? ((s3.h == 5'd23) ? 5'd0 : s3.h + 5'd1) : s3.h;

  always_comb begin
    state_nx = state;
    if (io.set_alarm || !io.enable) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (alarm_hit) state_nx = RINGING;
        RINGING: begin
          if (stp_edge)       state_nx = IDLE;
          else if (snz_edge)  state_nx = SNOOZE;
          else if (ring_done) state_nx = IDLE;
        end
        SNOOZE: begin
          if (stp_edge)     state_nx = IDLE;
          else if (snz_hit) state_nx = RINGING;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  assign enter_ring = (state_nx == RINGING) && (state != RINGING);

  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      s1       <= '0;
      s2       <= '0;
      s3       <= '0;
      last_seg <= '0;
      snz_sync <= '0;
      stp_sync <= '0;
      snz_prev <= 1'b0;
      stp_prev <= 1'b0;
      snz_edge <= 1'b0;
      stp_edge <= 1'b0;
    end else begin
      s1 <= '{h: io.horas, m: io.minutos, s: io.segundos};
      s2 <= s1;
      s3 <= s2;
      if (sec_tick) last_seg <= s3.s;
      snz_sync <= {snz_sync[0], io.snooze};
      stp_sync <= {stp_sync[0], io.stop};
      snz_prev <= snz_sync[1];
      stp_prev <= stp_sync[1];
      snz_edge <= snz_sync[1] & ~snz_prev;
      stp_edge <= stp_sync[1] & ~stp_prev;
    end
  end

  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      alarm_h <= '0;
      alarm_m <= '0;
      snz_h   <= '0;
      snz_m   <= '0;
    end else begin
      if (io.set_alarm && (io.ajuste_h <= 5'd23) && (io.ajuste_m <= 6'd59)) begin
        alarm_h <= io.ajuste_h;
        alarm_m <= io.ajuste_m;
      end
      if ((state == RINGING) && (state_nx == SNOOZE)) begin
        snz_h <= snz_h_nx;
        snz_m <= snz_m_nx;
      end
    end
  end

  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ring_cnt  <= '0;
      blink_cnt <= '0;
      led       <= 1'b0;
    end else begin
      state <= state_nx;
      if (enter_ring) begin
        ring_cnt  <= '0;
        blink_cnt <= '0;
        led       <= 1'b1;
      end else if ((state == RINGING) && (state_nx == RINGING)) begin
        if (sec_tick) ring_cnt <= ring_cnt + 16'd1;
        if (blink_cnt == 32'(BLINK_DIV - 1)) begin
          blink_cnt <= '0;
          led       <= ~led;
        end else begin
          blink_cnt <= blink_cnt + 32'd1;
        end
      end else begin
        led <= 1'b0;
      end
    end
  end

  assign io.alarm_h       = alarm_h;
  assign io.alarm_m       = alarm_m;
  assign io.ringing       = (state == RINGING);
  assign io.snooze_active = (state == SNOOZE);
  assign io.led           = led;
endmodule

// File: tb/tb_alarme.sv
// Bench for alarme: directed latency/blink/guard scenarios, then a random walk of time steps,
// button presses and alarm loads compared against a minute-of-day reference model.
module tb_alarme;
  localparam int BLINK_DIV  = 4;
  localparam int SNOOZE_MIN = 5;
  localparam int RING_SEC   = 60;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alarme_if io();

  alarme #(.BLINK_DIV(BLINK_DIV), .SNOOZE_MIN(SNOOZE_MIN), .RING_SEC(RING_SEC)) dut (
    .clock_50 (clk),
    .reset    (rst),
    .io       (io)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cur_h, cur_m, cur_s;
  logic en, sa;
  // reference model: 0 idle, 1 ringing, 2 snoozing; times as minute-of-day
  int m_st, m_cnt, m_snz, m_last_s, m_al_h, m_al_m;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".ringing"}, io.ringing, (m_st == 1));
    chk({tag, ".snooze_active"}, io.snooze_active, (m_st == 2));
    if (m_st != 1) chk({tag, ".led_off"}, io.led, 0);
  endtask

  task automatic model_time();
    int now;
    now = cur_h * 60 + cur_m;
    if (cur_s != m_last_s) begin
      m_last_s = cur_s;
      if (m_st == 1) begin
        m_cnt++;
        if (m_cnt == RING_SEC) m_st = 0;
      end else if (m_st == 0 && cur_s == 0 && now == m_al_h * 60 + m_al_m) begin
        m_st = 1; m_cnt = 0;
      end else if (m_st == 2 && cur_s == 0 && now == m_snz) begin
        m_st = 1; m_cnt = 0;
      end
    end
    if (sa || !en) m_st = 0;
  endtask

  task automatic drive_time(input int h, input int m, input int s);
    cur_h = h; cur_m = m; cur_s = s;
    io.horas = 5'(h); io.minutos = 6'(m); io.segundos = 6'(s);
  endtask

  task automatic step(input int h, input int m, input int s);
    drive_time(h, m, s);
    cyc(6);
    model_time();
    check_state("step");
  endtask

  task automatic advance();
    int h, m, s;
    h = cur_h; m = cur_m; s = cur_s + 1;
    if (s == 60) begin s = 0; m++; end
    if (m == 60) begin m = 0; h++; end
    if (h == 24) h = 0;
    step(h, m, s);
  endtask

  task automatic jump_before(input int tmin, input int k);
    int t;
    t = (tmin * 60 - k + 86400) % 86400;
    step(t / 3600, (t / 60) % 60, t % 60);
  endtask

  task automatic press(input logic snz, input logic stp);
    io.snooze = snz; io.stop = stp;
    cyc(3);
    io.snooze = 1'b0; io.stop = 1'b0;
    cyc(6);
    if (en) begin
      if (stp && m_st != 0) m_st = 0;
      else if (snz && m_st == 1) begin
        m_st  = 2;
        m_snz = (cur_h * 60 + cur_m + SNOOZE_MIN) % 1440;
      end
    end
    check_state("press");
  endtask

  task automatic load_alarm(input int h, input int m);
    io.set_alarm = 1'b1; io.ajuste_h = 5'(h); io.ajuste_m = 6'(m); sa = 1'b1;
    cyc(2);
    io.set_alarm = 1'b0; sa = 1'b0;
    cyc(1);
    if (h <= 23 && m <= 59) begin m_al_h = h; m_al_m = m; end
    m_st = 0;
    chk("alarm_h", io.alarm_h, m_al_h);
    chk("alarm_m", io.alarm_m, m_al_m);
    check_state("load");
  endtask

  task automatic set_en(input logic v);
    io.enable = v; en = v;
    cyc(4);
    if (!v) m_st = 0;
    check_state("enable");
  endtask

  initial begin
    io.snooze = 1'b0; io.stop = 1'b0; io.set_alarm = 1'b0;
    io.ajuste_h = '0; io.ajuste_m = '0; io.enable = 1'b1;
    en = 1'b1; sa = 1'b0;
    drive_time(0, 0, 0);
    m_st = 0; m_cnt = 0; m_snz = 0; m_last_s = 0; m_al_h = 0; m_al_m = 0;
    cyc(3);
    chk("rst.ringing", io.ringing, 0);
    chk("rst.led", io.led, 0);
    chk("rst.snooze_active", io.snooze_active, 0);
    chk("rst.alarm_h", io.alarm_h, 0);
    chk("rst.alarm_m", io.alarm_m, 0);
    rst = 1'b0;
    cyc(6);
    check_state("post_rst");

    // basic ring with exact latency and blink pattern
    load_alarm(6, 30);
    step(6, 29, 58);
    step(6, 29, 59);
    drive_time(6, 30, 0);
    cyc(3);
    chk("lat_e2.ringing", io.ringing, 0);
    cyc(1);
    chk("lat_e3.ringing", io.ringing, 1);
    chk("lat_e3.led", io.led, 1);
    for (int j = 1; j < 12; j++) begin
      cyc(1);
      chk("blink", io.led, ((j / BLINK_DIV) % 2 == 0));
    end
    model_time();
    check_state("ring");

    // stop latency, then no re-ring
    io.stop = 1'b1;
    cyc(3);
    chk("stop_e2.ringing", io.ringing, 1);
    cyc(1);
    chk("stop_e3.ringing", io.ringing, 0);
    chk("stop_e3.led", io.led, 0);
    io.stop = 1'b0;
    cyc(6);
    m_st = 0;
    step(6, 30, 1);
    step(6, 31, 0);
    chk("no_rering", io.ringing, 0);

    // snooze, then timeout of the snoozed ring
    load_alarm(6, 58);
    step(6, 57, 59);
    step(6, 58, 0);
    step(6, 58, 20);
    press(1'b1, 1'b0);
    chk("snooze.active", io.snooze_active, 1);
    step(7, 2, 59);
    chk("snooze.wait", io.ringing, 0);
    step(7, 3, 0);
    chk("snooze.ring", io.ringing, 1);
    for (int k = 0; k < RING_SEC - 1; k++) advance();
    chk("timeout.before", io.ringing, 1);
    advance();
    chk("timeout.after", io.ringing, 0);

    // snooze across midnight
    load_alarm(23, 57);
    step(23, 56, 59);
    step(23, 57, 0);
    press(1'b1, 1'b0);
    step(0, 1, 59);
    step(0, 2, 0);
    chk("wrap.ring", io.ringing, 1);

    // stop and snooze together
    press(1'b1, 1'b1);
    chk("both.snooze_active", io.snooze_active, 0);
    chk("both.ringing", io.ringing, 0);

    // guards
    load_alarm(24, 61);
    chk("guard.alarm_h", io.alarm_h, 23);
    chk("guard.alarm_m", io.alarm_m, 57);
    set_en(1'b0);
    step(23, 56, 59);
    step(23, 57, 0);
    chk("disabled.ringing", io.ringing, 0);
    set_en(1'b1);

    // reset mid-ring
    step(23, 56, 59);
    step(23, 57, 0);
    chk("pre_reset.ringing", io.ringing, 1);
    rst = 1'b1;
    #2;
    chk("mid_rst.ringing", io.ringing, 0);
    chk("mid_rst.led", io.led, 0);
    chk("mid_rst.snooze_active", io.snooze_active, 0);
    chk("mid_rst.alarm_h", io.alarm_h, 0);
    chk("mid_rst.alarm_m", io.alarm_m, 0);
    cyc(2);
    rst = 1'b0;
    m_st = 0; m_cnt = 0; m_last_s = 0; m_al_h = 0; m_al_m = 0; m_snz = 0;
    cyc(6);
    model_time();
    check_state("post_mid_rst");
    advance();
    advance();

    // random walk against the model
    load_alarm($urandom_range(0, 23), $urandom_range(0, 59));
    for (int it = 0; it < 1200; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 68) advance();
      else if (r < 74) jump_before(m_al_h * 60 + m_al_m, $urandom_range(0, 3));
      else if (r < 78) jump_before(m_snz, $urandom_range(0, 3));
      else if (r < 86) press(1'b1, 1'b0);
      else if (r < 91) press(1'b0, 1'b1);
      else if (r < 93) press(1'b1, 1'b1);
      else if (r < 95) set_en(!en);
      else if (r < 97) load_alarm($urandom_range(0, 31), $urandom_range(0, 63));
      else load_alarm($urandom_range(0, 23), $urandom_range(0, 59));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alarme.md
# alarme

Alarm unit for the chrono digital clock. Sits directly downstream of the seconds/minutes/hours counters: consumes their binary time values, holds a user-set alarm time, and drives a ring/snooze state machine with a blinking LED output. Runs entirely on the 50 MHz board clock, synchronising the ripple-clocked counter values before use.

## Interface

**Parameters**
- `BLINK_DIV`, default 25_000_000: `clock_50` cycles per LED toggle while ringing.
- `SNOOZE_MIN`, default 5: snooze length in minutes, 1..59.
- `RING_SEC`, default 60: seconds of ringing before automatic stop.

**Ports**

Clock and reset: one clock; reset is asynchronous and active-high.
- `clock_50`  in  1  the only clock; board 50 MHz.
- `reset`  in  1  asynchronous, active-high.

Time inputs and controls:
- `horas`  in  5  current hour from the hour counter, 0..23.
- `minutos`  in  6  current minute from the minute counter, 0..59.
- `segundos`  in  6  current second from the second counter, 0..59.
- `enable`  in  1  alarm armed (switch level).
- `set_alarm`  in  1  load alarm time while high (switch level).
- `ajuste_h`  in  5  alarm hour to load.
- `ajuste_m`  in  6  alarm minute to load.
- `snooze`  in  1  snooze button, active-high, debounced externally.
- `stop`  in  1  stop button, active-high, debounced externally.

Outputs:
- `alarm_h`  out  5  stored alarm hour, for display.
- `alarm_m`  out  6  stored alarm minute, for display.
- `ringing`  out  1  high in RINGING.
- `led`  out  1  blink output; 0 outside RINGING.
- `snooze_active`  out  1  high in SNOOZE.

## Operation

**Input synchronisation**
- The 17-bit time bus passes through three register stages: s1, s2, s3.
- The bus is stable when s2 == s3.
- `sec_tick` is a one-cycle pulse when the bus is stable and s3.segundos differs from the `last_seg` register. `last_seg` loads s3.segundos on each tick.
- `last_seg` resets to 0, so a reset with `segundos`=0 produces no tick.

**Buttons**
- `snooze` and `stop` each pass through 2 synchronising flops.
- Each acts on its synchronised rising edge only. Holding a button produces no repeat action.

**Alarm registers**
- While `set_alarm`=1, `alarm_h`/`alarm_m` load `ajuste_h`/`ajuste_m` every cycle, provided `ajuste_h`≤23 and `ajuste_m`≤59.
- An out-of-range value leaves both registers unchanged. Reset value: 00:00.

**State machine: IDLE, RINGING, SNOOZE**
- `set_alarm`=1 or `enable`=0 forces IDLE from any state. This has priority over all transitions below.
- IDLE→RINGING: `sec_tick` with synced time == `alarm_h`:`alarm_m`:00.
- RINGING→IDLE:
  - on a `stop` edge;
  - on a `sec_tick` that brings `ring_cnt` to `RING_SEC`.
- RINGING→SNOOZE: on a `snooze` edge.
  - `snz_h:snz_m` = synced current h:m + `SNOOZE_MIN`.
  - Minute wraps at 60 (carry into hour). Hour wraps 23→0.
- SNOOZE→RINGING: `sec_tick` with synced time == `snz_h`:`snz_m`:00.
- SNOOZE→IDLE: on a `stop` edge.
- `stop` and `snooze` edges in the same cycle: `stop` wins (→IDLE).
- `ring_cnt` counts `sec_tick`s in RINGING and clears on every entry to RINGING.

**Blink**
- The blink counter clears on entry to RINGING. `led`=1 on the first RINGING cycle.
- `led` toggles each `BLINK_DIV` cycles thereafter.
- `led` is forced to 0 in other states.

## Timing

- Reset: all outputs 0, state IDLE, all sync registers, counters and `last_seg` cleared. Takes effect immediately (asynchronous).
- Time-match latency: if `segundos` changes before edge 0, `sec_tick` is high between edges 2 and 3. State, `ringing`, `snooze_active` and `led` update at edge 3.
- Button latency: button rises before edge 0; the synchronised edge is detected at edge 2; state updates at edge 3.
- `set_alarm` loads take effect at the next edge (1-cycle latency to `alarm_h`/`alarm_m`).
- All outputs are registered; no combinational path from inputs to outputs.
- Glitches on the time bus from ripple-clocked counters, shorter than 2 clock_50 cycles, never produce a tick.

## Test plan

1. **Basic ring:** `BLINK_DIV`=4, `enable`=1, set alarm 06:30. Step time 06:29:59→06:30:00 → `ringing`=1 three edges later; `led`=1 then toggles every 4 cycles.
2. **Stop:** pulse `stop` while ringing → IDLE, `ringing`=`led`=0 within 3 edges. 06:30:01 and 06:31:00 cause no re-ring.
3. **Snooze and wrap:** `SNOOZE_MIN`=5, press `snooze` at 06:58:20 → `snooze_active`=1; rings at 07:03:00. Repeat at 23:57 → rings at 00:02:00.
4. **Timeout:** `RING_SEC`=60, no buttons → `ringing` falls on the tick at 06:31:00.
5. **Guards:** `set_alarm` with 24:61 → `alarm_h`/`alarm_m` unchanged. `enable`=0 at match → no ring. `stop`+`snooze` in the same cycle → IDLE, `snooze_active`=0.
6. **Reset mid-ring:** assert `reset` while RINGING → all outputs 0 immediately, `alarm_h`/`alarm_m`=00:00. After release, no ring until a new match tick.
